snn_layer_stream: RTL

Parametrised spiking-neuron layer with a streaming, word-serial current loader, double-buffered input registers and an integrated SNN tick generator. It generalises the fixed hidden/output packing scheme to any neuron count, data width and bus width, and adds a valid/ready handshake, frame framing checks and tick-aligned atomic commit. One instance is placed per layer under the SNN top level, fed by the weight/current streaming logic.

---
 rtl/snn_layer_stream_if.sv | 16 +
 rtl/snn_layer_stream.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/snn_layer_stream_if.sv
// Stream port of the spiking-neuron layer loader.
// Handshake: a word (a "beat") transfers on a rising edge where in_valid and
// in_ready are both 1. The master holds in_data/in_start/in_last stable while
// in_valid is high and not yet accepted; in_ready never depends on in_valid.
interface snn_layer_stream_if #(
  parameter int BUS_W = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] in_data;
  logic             in_start;
  logic             in_last;

  modport master (output in_valid, in_data, in_start, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_start, in_last, output in_ready);
endinterface

// File: rtl/snn_layer_stream.sv
// Spiking-neuron layer: word-serial current loader into a shadow register,
// tick-aligned commit into the active register, tick generator and a bank of
// leaky integrate-and-fire neurons fed from the active register.
module snn_layer_stream #(
  parameter int NUM_NEURONS    = 30,
  parameter int DATA_W         = 16,
  parameter int BUS_W          = 32,
  parameter int MEM_W          = 20,
  parameter int THRESHOLD      = 'h2000,
  parameter int SHIFT_VALUE    = 7,
  parameter int CLK_DIV_FACTOR = 1000
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   enable,
  snn_layer_stream_if.slave      s_if,
  output logic                   snn_tick,
  output logic [NUM_NEURONS-1:0] o_spike,
  output logic                   frame_loaded,
  output logic                   frame_err,
  output logic [1:0]             dbg_state
);
  localparam int L     = BUS_W / DATA_W;
  localparam int WORDS = (NUM_NEURONS + L - 1) / L;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = $clog2(CLK_DIV_FACTOR);
  localparam int ACT_W = NUM_NEURONS * DATA_W;
  localparam int EXT_W = MEM_W + 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CLK_DIV_FACTOR - 1);

  localparam logic signed [MEM_W-1:0] MEM_MAX   = {1'b0, {(MEM_W-1){1'b1}}};
  localparam logic signed [MEM_W-1:0] MEM_MIN   = {1'b1, {(MEM_W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] MEM_MAX_X = {2'b00, MEM_MAX};
  localparam logic signed [EXT_W-1:0] MEM_MIN_X = {2'b11, MEM_MIN};
  localparam logic signed [EXT_W-1:0] THR_X     = EXT_W'(THRESHOLD);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_WAIT = 2'd2} state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [ACT_W-1:0]        shadow_q, active_q, shadow_wr;
  logic [IDX_W-1:0]        wr_slot;
  logic                    err_q, loaded_q, tick_q, beat;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [MEM_W-1:0] mem_q  [NUM_NEURONS];
  logic signed [MEM_W-1:0] mem_nx [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]  fire, spike_q;

  // One leak-and-integrate step with saturation to the membrane range.
  function automatic logic signed [MEM_W-1:0] leak_integrate(
    input logic signed [MEM_W-1:0]  v,
    input logic signed [DATA_W-1:0] cur
  );
    logic signed [MEM_W-1:0] leak;
    logic signed [EXT_W-1:0] sum;
    leak = v >>> SHIFT_VALUE;
    sum  = $signed({{2{v[MEM_W-1]}}, v}) - $signed({{2{leak[MEM_W-1]}}, leak})
         + $signed({{(EXT_W-DATA_W){cur[DATA_W-1]}}, cur});
    if (sum > MEM_MAX_X)      leak_integrate = MEM_MAX;
    else if (sum < MEM_MIN_X) leak_integrate = MEM_MIN;
    else                      leak_integrate = sum[MEM_W-1:0];
  endfunction

  assign s_if.in_ready = (state_q != S_WAIT);
  assign beat          = s_if.in_valid && (state_q != S_WAIT);
  assign snn_tick      = tick_q;
  assign o_spike       = spike_q;
  assign frame_loaded  = loaded_q;
  assign frame_err     = err_q;
  assign dbg_state     = state_q;

  // Tick counter next value: 0..CLK_DIV_FACTOR-1, wrapping.
  always_comb begin
    cnt_d = (cnt_q == CNT_TOP) ? '0 : cnt_q + CNT_W'(1);
  end

  // Tick pulse is registered so it is high exactly while the counter sits at its top value.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CNT_TOP);
    end
  end

  // Shadow image with the current word merged into its slot; a start word always lands in slot 0.
  always_comb begin
    wr_slot   = s_if.in_start ? '0 : idx_q;
    shadow_wr = shadow_q;
    for (int j = 0; j < L; j++) begin
      if (int'(wr_slot) * L + j < NUM_NEURONS)
        shadow_wr[(int'(wr_slot) * L + j) * DATA_W +: DATA_W] = s_if.in_data[j*DATA_W +: DATA_W];
    end
  end

  // Loader FSM: fills the shadow word by word, checks framing, commits to active on a tick.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      err_q    <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      err_q    <= 1'b0;
      loaded_q <= 1'b0;
      case (state_q)
        S_IDLE, S_FILL: begin
          if (beat) begin
            if (s_if.in_start) begin
              shadow_q <= shadow_wr;
              if (state_q == S_FILL) err_q <= 1'b1;
              if (s_if.in_last || WORDS == 1) begin
                idx_q <= '0;
                if (s_if.in_last && WORDS == 1) begin
                  state_q <= S_WAIT;
                end else begin
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
                end
              end else begin
                idx_q   <= IDX_W'(1);
                state_q <= S_FILL;
              end
            end else if (state_q == S_IDLE) begin
              err_q <= 1'b1;
            end else begin
              shadow_q <= shadow_wr;
              if (idx_q == LAST_IDX) begin
                idx_q <= '0;
                if (s_if.in_last) begin
                  state_q <= S_WAIT;
                end else begin
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
                end
              end else if (s_if.in_last) begin
                idx_q   <= '0;
                err_q   <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                idx_q <= idx_q + IDX_W'(1);
              end
            end
          end
        end
        S_WAIT: begin
          if (tick_q) begin
            active_q <= shadow_q;
            loaded_q <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Candidate membrane values and fire decisions, always from the active register.
  always_comb begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      mem_nx[i] = leak_integrate(mem_q[i], active_q[i*DATA_W +: DATA_W]);
      fire[i]   = ($signed({{2{mem_nx[i][MEM_W-1]}}, mem_nx[i]}) >= THR_X);
    end
  end

  // Neurons update only on an enabled tick; firing resets the membrane to 0.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) mem_q[i] <= '0;
    end else begin
      spike_q <= '0;
      if (tick_q && enable) begin
        spike_q <= fire;
        for (int i = 0; i < NUM_NEURONS; i++) mem_q[i] <= fire[i] ? '0 : mem_nx[i];
      end
    end
  end
endmodule
